nvram_upload: RTL
=================

NVRAM_UPLOAD -- requirements
Module: nvram_upload

Interface
REQ-001 Parameter ADDR_W, default 10: NVRAM address width; 2^ADDR_W bytes are exposed to the HPS.
REQ-002 Parameter INDEX, default 8'd4: ioctl_index value this block answers.
REQ-003 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ioctl_upload  in  1  HPS upload session active.
REQ-006 ioctl_index  in  8  upload target index.
REQ-007 ioctl_rd  in  1  one-cycle read strobe from HPS.
REQ-008 ioctl_addr  in  25  byte address of the read.
REQ-009 ioctl_din  out  8  read data returned to HPS.
REQ-010 ioctl_wait  out  1  HPS stall; ioctl_din is valid when this is low.
REQ-011 ram_addr  out  ADDR_W  NVRAM read address.
REQ-012 ram_rd  out  1  NVRAM read enable.
REQ-013 ram_q  in  8  NVRAM data, one-cycle synchronous latency after ram_rd.
REQ-014 cpu_pause  out  1  request to halt the game CPU.
REQ-015 cpu_paused  in  1  game CPU halt acknowledge.
REQ-016 nv_wr  in  1  game CPU NVRAM write pulse (used only with NVRAM_DIRTY_EN).
REQ-017 save_pending  out  1  NVRAM modified since the last complete upload.

Function
REQ-018 The session is active when ioctl_upload is 1 and ioctl_index equals INDEX; all other traffic is ignored.
REQ-019 The FSM has five states: IDLE, PAUSE, READY, FETCH, DATA.
REQ-020 IDLE -> PAUSE on the session becoming active; cpu_pause is 1 in every state except IDLE.
REQ-021 PAUSE -> READY on the first cycle cpu_paused is 1; ioctl_wait is 1 throughout PAUSE.
REQ-022 During PAUSE, one ioctl_rd is latched with its address and serviced on entry to READY; a second rd in PAUSE overwrites the first.
REQ-023 READY with ioctl_rd (or a latched request), in-range address (ioctl_addr[24:ADDR_W] == 0) -> FETCH.
REQ-024 In FETCH: ram_addr = ioctl_addr[ADDR_W-1:0] and ram_rd = 1 for exactly one cycle.
REQ-025 FETCH -> DATA; DATA captures ram_q into ioctl_din, then -> READY.
REQ-026 Latency: rd sampled at edge N gives ioctl_wait = 1 from cycle N+1 and ioctl_din valid with ioctl_wait = 0 at N+3.
REQ-027 Out-of-range address in READY: ioctl_din = 8'hFF and ioctl_wait = 1 for exactly one cycle (N+1), low at N+2; no ram_rd is issued.
REQ-028 ioctl_rd arriving while in FETCH or DATA is ignored.
REQ-029 Session ends (ioctl_upload falls or ioctl_index changes) in any state -> IDLE next cycle; cpu_pause = 0, ioctl_wait = 0, ram_rd = 0, ioctl_din holds its last value.
REQ-030 ram_rd is 0 outside FETCH; ram_addr holds its last value.

Reset
REQ-031 On reset_n low, immediately: state IDLE, ioctl_din = 8'h00, ioctl_wait = 0, ram_rd = 0, ram_addr = 0, cpu_pause = 0, pending request cleared, save_pending = 0.
REQ-032 Reset asserted mid-FETCH or mid-DATA discards the read; no ram_rd is issued after reset release until a new session starts.

Configuration
REQ-033 Macro NVRAM_DIRTY_EN.
- Defined: save_pending is set by nv_wr and cleared on the cycle DATA completes a read of address 2^ADDR_W-1.
- If nv_wr and that clear occur in the same cycle, set wins.
REQ-034 Without NVRAM_DIRTY_EN: save_pending is constant 0, nv_wr is unused, and no dirty flop exists.

Verification
REQ-035 Session active, cpu_paused held 0 for 20 cycles then 1 -> cpu_pause = 1 from the cycle after session start, ioctl_wait = 1 for all 20 cycles, READY the cycle after ack.
REQ-036 READY, ram[0x123] = 8'hA5, rd addr 0x123 at edge N -> ram_rd at N+1 with ram_addr = 0x123, ioctl_din = 8'hA5 and ioctl_wait = 0 at N+3.
REQ-037 rd addr 0x400 (ADDR_W = 10) -> ioctl_din = 8'hFF, ioctl_wait high one cycle only, no ram_rd.
REQ-038 ioctl_upload dropped during FETCH -> IDLE next cycle, cpu_pause = 0, ioctl_wait = 0, ioctl_din unchanged.
REQ-039 With NVRAM_DIRTY_EN: nv_wr pulse -> save_pending = 1; read of 0x3FF -> save_pending = 0; nv_wr in the same cycle as that clear -> save_pending stays 1.
REQ-040 reset_n pulsed low during DATA -> all outputs at reset values asynchronously; the next read after a new session returns correct data.

Source files
------------

// File: rtl/nvram_upload.sv
// -----------------------------------------------------------------------------
// nvram_upload
//   Serves HPS upload reads of a game NVRAM. While an upload session for INDEX
//   is open the game CPU is held paused. Each HPS read strobe becomes one
//   synchronous RAM read, and the returned byte is handed back on ioctl_din.
//
// Optional feature (macro NVRAM_DIRTY_EN):
//   When defined, save_pending is set by nv_wr. It clears when a read of the
//   last NVRAM byte completes, which marks the end of a full upload. When
//   undefined, save_pending is tied to 0 and nv_wr is unused.
//
// Ports
//   clk_sys      in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   ioctl_upload in   HPS upload session active
//   ioctl_index  in   upload target index (8)
//   ioctl_rd     in   one-cycle HPS read strobe
//   ioctl_addr   in   HPS byte address (25)
//   ioctl_din    out  read data to HPS (8)
//   ioctl_wait   out  HPS stall; ioctl_din valid while low
//   ram_addr     out  NVRAM read address (ADDR_W)
//   ram_rd       out  NVRAM read enable
//   ram_q        in   NVRAM data, one cycle after ram_rd (8)
//   cpu_pause    out  game CPU halt request
//   cpu_paused   in   game CPU halt acknowledge
//   nv_wr        in   game CPU NVRAM write pulse
//   save_pending out  NVRAM modified since the last complete upload
// -----------------------------------------------------------------------------
module nvram_upload #(
    parameter int          ADDR_W = 10,
    parameter logic [7:0]  INDEX  = 8'd4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    output logic              cpu_pause,
    input  logic              cpu_paused,
    input  logic              nv_wr,
    output logic              save_pending
);

    typedef enum logic [2:0] {
        IDLE,
        PAUSE,
        READY,
        FETCH,
        DATA
    } state_t;

    state_t      state;
    logic        pend;
    logic [24:0] pend_addr;

    logic        active;
    logic        req;
    logic [24:0] req_addr;
    logic        in_range;
    logic        data_done;

    assign active    = ioctl_upload && (ioctl_index == INDEX);
    // A live strobe is newer than a request parked during PAUSE, so it wins.
    assign req       = ioctl_rd || pend;
    assign req_addr  = ioctl_rd ? ioctl_addr : pend_addr;
    assign in_range  = (req_addr >> ADDR_W) == 25'd0;
    assign data_done = active && (state == DATA);

    // NOTE: every register here is updated with non-blocking assignments so
    // that all next-state terms read values from before the clock edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            ram_rd     <= 1'b0;
            ram_addr   <= '0;
            cpu_pause  <= 1'b0;
            pend       <= 1'b0;
            pend_addr  <= '0;
        end else if (!active) begin
            // Session closed: release the CPU and the HPS. ioctl_din and
            // ram_addr keep their last values.
            state      <= IDLE;
            cpu_pause  <= 1'b0;
            ioctl_wait <= 1'b0;
            ram_rd     <= 1'b0;
            pend       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= PAUSE;
                    cpu_pause  <= 1'b1;
                    ioctl_wait <= 1'b1;
                    pend       <= 1'b0;
                end
                PAUSE: begin
                    if (ioctl_rd) begin
                        pend      <= 1'b1;
                        pend_addr <= ioctl_addr;
                    end
                    if (cpu_paused) begin
                        state      <= READY;
                        // Keep stalling if a parked read still has to be served.
                        ioctl_wait <= ioctl_rd || pend;
                    end
                end
                READY: begin
                    ioctl_wait <= 1'b0;
                    if (req) begin
                        pend       <= 1'b0;
                        ioctl_wait <= 1'b1;
                        if (in_range) begin
                            state    <= FETCH;
                            ram_rd   <= 1'b1;
                            ram_addr <= req_addr[ADDR_W-1:0];
                        end else begin
                            ioctl_din <= 8'hFF;
                        end
                    end
                end
                FETCH: begin
                    ram_rd <= 1'b0;
                    state  <= DATA;
                end
                DATA: begin
                    ioctl_din  <= ram_q;
                    ioctl_wait <= 1'b0;
                    state      <= READY;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef NVRAM_DIRTY_EN
    logic dirty;

    // A write in the same cycle as the final-byte read keeps the flag set.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dirty <= 1'b0;
        end else if (nv_wr) begin
            dirty <= 1'b1;
        end else if (data_done && (ram_addr == '1)) begin
            dirty <= 1'b0;
        end
    end

    assign save_pending = dirty;
`else
    logic unused_inputs;

    assign unused_inputs = nv_wr ^ data_done;
    assign save_pending  = 1'b0;
`endif

endmodule
